// File: rtl/xgs_axis_frame_gen.sv
// rtl/xgs_axis_frame_gen.sv - AXI4-Stream video frame source with SOF/EOF/SOL/EOL sideband
// Emits YSIZE lines of XSIZE beats per start pulse with a payload the scoreboard can predict.
module xgs_axis_frame_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int XSIZE_WIDTH = 12,
  parameter int YSIZE_WIDTH = 12,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   sclk,
  input  logic                   srst,
  input  logic                   start,
  input  logic [XSIZE_WIDTH-1:0] x_size,
  input  logic [YSIZE_WIDTH-1:0] y_size,
  input  logic [GAP_WIDTH-1:0]   line_gap,
  input  logic [1:0]             pattern_sel,
  input  logic [7:0]             seed,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_id,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [3:0]             m_axis_tuser,
  output logic                   m_axis_tlast
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [7:0] NB8 = 8'(NB);

  typedef enum logic [1:0] {IDLE, LINE, GAP, DONE} state_t;

  state_t                 state, state_nx;
  logic [XSIZE_WIDTH-1:0] x_cnt, x_nx, x_last, x_last_in, x_last_sel;
  logic [YSIZE_WIDTH-1:0] y_cnt, y_nx, y_last, y_last_in, y_last_sel;
  logic [GAP_WIDTH-1:0]   gap_cnt, gap_cnt_nx, gap_len;
  logic [1:0]             pat, pat_sel;
  logic [7:0]             seed_r, seed_sel;
  logic                   fire, load, drop;
  logic                   sof, eof, sol, eol;

  function automatic logic [DATA_WIDTH-1:0] beat_data(
    input logic [1:0]             p,
    input logic [7:0]             s,
    input logic [7:0]             fid,
    input logic [XSIZE_WIDTH-1:0] x,
    input logic [YSIZE_WIDTH-1:0] y
  );
    logic [DATA_WIDTH-1:0] d;
    logic [7:0]            base;
    logic [7:0]            b;
    logic [2:0]            sh;
    d    = '0;
    base = s + 8'(y) + 8'(x) * NB8;
    sh   = 3'(x) + 3'(y);
    for (int k = 0; k < NB; k++) begin
      case (p)
        2'd0:    b = base + 8'(k);
        2'd1:    b = s;
        2'd2:    b = 8'd1 << sh;
        default: b = fid ^ s;
      endcase
      d[k*8 +: 8] = b;
    end
    return d;
  endfunction

  // Zero sizes behave as one; store the index of the last beat/line instead of the size.
  assign x_last_in  = (x_size == '0) ? '0 : x_size - 1'b1;
  assign y_last_in  = (y_size == '0) ? '0 : y_size - 1'b1;
  assign x_last_sel = (state == IDLE) ? x_last_in   : x_last;
  assign y_last_sel = (state == IDLE) ? y_last_in   : y_last;
  assign pat_sel    = (state == IDLE) ? pattern_sel : pat;
  assign seed_sel   = (state == IDLE) ? seed        : seed_r;
  assign fire       = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    drop       = 1'b0;
    x_nx       = x_cnt;
    y_nx       = y_cnt;
    gap_cnt_nx = gap_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LINE;
          load     = 1'b1;
          x_nx     = '0;
          y_nx     = '0;
        end
      end
      LINE: begin
        if (fire) begin
          if (x_cnt != x_last) begin
            load = 1'b1;
            x_nx = x_cnt + 1'b1;
          end else if (y_cnt == y_last) begin
            state_nx = DONE;
            drop     = 1'b1;
          end else if (gap_len == '0) begin
            load = 1'b1;
            x_nx = '0;
            y_nx = y_cnt + 1'b1;
          end else begin
            state_nx   = GAP;
            drop       = 1'b1;
            gap_cnt_nx = gap_len;
          end
        end
      end
      GAP: begin
        gap_cnt_nx = gap_cnt - 1'b1;
        if (gap_cnt == GAP_WIDTH'(1)) begin
          state_nx = LINE;
          load     = 1'b1;
          x_nx     = '0;
          y_nx     = y_cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sol = (x_nx == '0);
  assign sof = sol && (y_nx == '0);
  assign eol = (x_nx == x_last_sel);
  assign eof = eol && (y_nx == y_last_sel);

  always_ff @(posedge sclk) begin
    if (srst) begin
      state         <= IDLE;
      x_cnt         <= '0;
      y_cnt         <= '0;
      x_last        <= '0;
      y_last        <= '0;
      gap_cnt       <= '0;
      gap_len       <= '0;
      pat           <= '0;
      seed_r        <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_id      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state   <= state_nx;
      x_cnt   <= x_nx;
      y_cnt   <= y_nx;
      gap_cnt <= gap_cnt_nx;
      if (state == IDLE && start) begin
        x_last  <= x_last_in;
        y_last  <= y_last_in;
        gap_len <= line_gap;
        pat     <= pattern_sel;
        seed_r  <= seed;
      end
      // The next beat is loaded on the same edge that retires the current one.
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat_data(pat_sel, seed_sel, frame_id[7:0], x_nx, y_nx);
        m_axis_tuser  <= {eol, sol, eof, sof};
        m_axis_tlast  <= eol;
      end else if (drop) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tuser  <= '0;
        m_axis_tlast  <= 1'b0;
      end
      busy       <= (state_nx != IDLE);
      frame_done <= (state_nx == DONE);
      if (state == LINE && state_nx == DONE) frame_id <= frame_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_xgs_axis_frame_gen.sv
// tb/tb_xgs_axis_frame_gen.sv - self-checking bench for xgs_axis_frame_gen
// Table vectors, random frames against a beat-list reference model, reset/ignore/wrap sequences.
module tb_xgs_axis_frame_gen;
  localparam int DW = 64;
  localparam int XW = 12;
  localparam int YW = 12;
  localparam int GW = 8;
  localparam int NB = DW / 8;

  logic          sclk = 1'b0;
  logic          srst;
  logic          start;
  logic [XW-1:0] x_size;
  logic [YW-1:0] y_size;
  logic [GW-1:0] line_gap;
  logic [1:0]    pattern_sel;
  logic [7:0]    seed;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_id;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [3:0]    m_axis_tuser;
  logic          m_axis_tlast;

  xgs_axis_frame_gen #(.DATA_WIDTH(DW), .XSIZE_WIDTH(XW), .YSIZE_WIDTH(YW), .GAP_WIDTH(GW)) dut (
    .sclk(sclk), .srst(srst), .start(start), .x_size(x_size), .y_size(y_size),
    .line_gap(line_gap), .pattern_sel(pattern_sel), .seed(seed), .busy(busy),
    .frame_done(frame_done), .frame_id(frame_id), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 sclk = ~sclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: payload of beat (x,y) straight from the pattern rules.
  function automatic logic [63:0] model_beat(int x, int y, int p, int sd, int fid);
    logic [63:0] d;
    int b;
    d = '0;
    for (int k = 0; k < NB; k++) begin
      case (p)
        0:       b = (sd + y + x * NB + k) % 256;
        1:       b = sd;
        2:       b = 1 << ((x + y) % 8);
        default: b = (fid % 256) ^ sd;
      endcase
      d[k*8 +: 8] = 8'(b);
    end
    return d;
  endfunction

  logic [63:0] exp_data[$];
  logic [3:0]  exp_user[$];
  logic        exp_last[$];
  logic [63:0] obs_data[$];
  logic [3:0]  obs_user[$];
  logic        obs_last[$];
  int          idle_cnt, done_cnt, hold_err, done_err;
  bit          prev_eof, prev_stall, rnd_ready;
  logic [63:0] prev_data;
  logic [3:0]  prev_user;
  logic        prev_last;
  int          model_fid = 0;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge sclk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge sclk);
      if (!srst) begin
        if (busy && !m_axis_tvalid) idle_cnt++;
        if (frame_done) begin
          done_cnt++;
          if (!prev_eof) done_err++;
        end
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data ||
                           m_axis_tuser != prev_user || m_axis_tlast != prev_last))
          hold_err++;
        if (m_axis_tvalid && m_axis_tready) begin
          obs_data.push_back(m_axis_tdata);
          obs_user.push_back(m_axis_tuser);
          obs_last.push_back(m_axis_tlast);
        end
        prev_eof   = m_axis_tvalid && m_axis_tready && m_axis_tuser[1];
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_user  = m_axis_tuser;
        prev_last  = m_axis_tlast;
      end
    end
  end

  task automatic run_frame(input int xs, input int ys, input int gap, input int pat,
                           input int sd, input bit rnd, input bit ign);
    int xe, ye, cyc;
    xe = (xs == 0) ? 1 : xs;
    ye = (ys == 0) ? 1 : ys;
    exp_data.delete(); exp_user.delete(); exp_last.delete();
    obs_data.delete(); obs_user.delete(); obs_last.delete();
    idle_cnt = 0; done_cnt = 0; hold_err = 0; done_err = 0;
    for (int y = 0; y < ye; y++)
      for (int x = 0; x < xe; x++) begin
        exp_data.push_back(model_beat(x, y, pat, sd, model_fid));
        exp_user.push_back({x == xe - 1, x == 0, (x == xe - 1) && (y == ye - 1), (x == 0) && (y == 0)});
        exp_last.push_back(x == xe - 1);
      end
    rnd_ready = rnd;
    @(posedge sclk); #1;
    x_size = XW'(xs); y_size = YW'(ys); line_gap = GW'(gap);
    pattern_sel = 2'(pat); seed = 8'(sd); start = 1'b1;
    @(posedge sclk); #1;
    start = 1'b0;
    @(negedge sclk);
    check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("latency_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 20000) begin
      start = ign && (cyc == 2);
      @(negedge sclk);
      cyc++;
    end
    start = 1'b0;
    check("done_timeout", 64'(cyc < 20000), 64'd1);
    if (ign) begin
      start = 1'b1;
      @(posedge sclk); #1;
      start = 1'b0;
    end
    repeat (4) @(negedge sclk);
    rnd_ready = 1'b0;
    model_fid = (model_fid + 1) & 16'hFFFF;
    check("busy_after", 64'(busy), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("done_timing", 64'(done_err), 64'd0);
    check("stall_hold", 64'(hold_err), 64'd0);
    check("idle_cycles", 64'(idle_cnt), 64'(gap * (ye - 1) + 1));
    check("frame_id", 64'(frame_id), 64'(model_fid));
    check("beat_count", 64'(obs_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      check("beat_data", obs_data[i], exp_data[i]);
      check("beat_user", 64'(obs_user[i]), 64'(exp_user[i]));
      check("beat_last", 64'(obs_last[i]), 64'(exp_last[i]));
    end
  endtask

  typedef struct {
    int         xs, ys, gap, pat, sd;
    bit         rnd;
    int         beats;
    logic [7:0] b0_first, b0_last;
    logic [3:0] u_first;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{xs: 4, ys: 3, gap: 2, pat: 0, sd: 8'h10, rnd: 0, beats: 12, b0_first: 8'h10, b0_last: 8'h2A, u_first: 4'b0101};
    tbl[1] = '{xs: 4, ys: 3, gap: 2, pat: 0, sd: 8'h10, rnd: 1, beats: 12, b0_first: 8'h10, b0_last: 8'h2A, u_first: 4'b0101};
    tbl[2] = '{xs: 0, ys: 0, gap: 5, pat: 1, sd: 8'hA5, rnd: 0, beats: 1,  b0_first: 8'hA5, b0_last: 8'hA5, u_first: 4'b1111};
    tbl[3] = '{xs: 5, ys: 2, gap: 0, pat: 2, sd: 8'h77, rnd: 0, beats: 10, b0_first: 8'h01, b0_last: 8'h20, u_first: 4'b0101};
    tbl[4] = '{xs: 3, ys: 4, gap: 1, pat: 3, sd: 8'h3C, rnd: 1, beats: 12, b0_first: 8'h38, b0_last: 8'h38, u_first: 4'b0101};
    tbl[5] = '{xs: 2, ys: 1, gap: 3, pat: 0, sd: 8'hFF, rnd: 1, beats: 2,  b0_first: 8'hFF, b0_last: 8'h07, u_first: 4'b0101};

    srst = 1'b1; start = 1'b0; x_size = '0; y_size = '0; line_gap = '0;
    pattern_sel = '0; seed = '0; rnd_ready = 1'b0;
    repeat (3) @(posedge sclk);
    #1 srst = 1'b0;
    @(negedge sclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_frame_id", 64'(frame_id), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tuser", 64'(m_axis_tuser), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);

    // Abort an 8x4 ramp frame while beat (3,2) is on the bus.
    @(posedge sclk); #1;
    x_size = 12'd8; y_size = 12'd4; line_gap = 8'd0; pattern_sel = 2'd0; seed = 8'd0; start = 1'b1;
    @(posedge sclk); #1;
    start = 1'b0;
    @(negedge sclk);
    repeat (19) @(negedge sclk);
    check("abort_beat_x3y2", 64'(m_axis_tdata[7:0]), 64'd26);
    check("abort_beat_user", 64'(m_axis_tuser), 64'd0);
    done_cnt = 0;
    srst = 1'b1;
    @(posedge sclk); #1;
    srst = 1'b0;
    @(negedge sclk);
    check("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_frame_id", 64'(frame_id), 64'd0);
    repeat (3) @(negedge sclk);
    check("abort_no_done", 64'(done_cnt), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].xs, tbl[i].ys, tbl[i].gap, tbl[i].pat, tbl[i].sd, tbl[i].rnd, 1'b0);
      check("tbl_beats", 64'(obs_data.size()), 64'(tbl[i].beats));
      if (obs_data.size() > 0) begin
        check("tbl_first_byte", 64'(obs_data[0][7:0]), 64'(tbl[i].b0_first));
        check("tbl_last_byte", 64'(obs_data[obs_data.size()-1][7:0]), 64'(tbl[i].b0_last));
        check("tbl_first_user", 64'(obs_user[0]), 64'(tbl[i].u_first));
      end
      if (i == 0 && obs_data.size() > 9) check("ramp_x1y2_byte0", 64'(obs_data[9][7:0]), 64'h1A);
    end
    check("fid_after_table", 64'(frame_id), 64'd6);

    run_frame(3, 2, 1, 0, 8'h22, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++)
      run_frame($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b0);

    @(negedge sclk);
    force dut.frame_id = 16'hFFFE;
    #1;
    release dut.frame_id;
    check("fid_preset", 64'(frame_id), 64'hFFFE);
    model_fid = 16'hFFFE;
    run_frame(1, 1, 0, 3, 8'h5A, 1'b0, 1'b0);
    if (obs_data.size() > 0) check("fid_fill_FFFE", 64'(obs_data[0][7:0]), 64'hA4);
    run_frame(1, 1, 0, 3, 8'h5A, 1'b0, 1'b0);
    check("fid_wrap", 64'(frame_id), 64'h0000);
    if (obs_data.size() > 0) check("fid_fill_FFFF", 64'(obs_data[0][7:0]), 64'hA5);
    run_frame(1, 1, 0, 3, 8'h5A, 1'b0, 1'b0);
    if (obs_data.size() > 0) check("fid_fill_0000", 64'(obs_data[0][7:0]), 64'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
